// File: rtl/spi_frame_master.sv
// SPI mode-0 frame transmitter: streams FRAME_BYTES bytes from a valid/ready source
// under a single chip-select assertion, MSB first, SCK idling low.
module spi_frame_master #(
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned FRAME_BYTES = 16384,
  parameter int unsigned CS_SETUP    = 2,
  parameter int unsigned CS_HOLD     = 2,
  parameter int unsigned CS_GAP      = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        spi_clk,
  output logic        spi_cs,
  output logic        spi_mosi,
  output logic        busy,
  output logic        frame_done,
  output logic [14:0] byte_count
);

  localparam int unsigned DivW   = $clog2(CLK_DIV);
  localparam int unsigned TmrMax = (CS_SETUP > CS_HOLD) ?
                                   ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP) :
                                   ((CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP);
  localparam int unsigned TmrW   = $clog2(TmrMax + 1);

  if (CLK_DIV < 2 || FRAME_BYTES == 0 || FRAME_BYTES > 16384 ||
      CS_SETUP == 0 || CS_HOLD == 0 || CS_GAP == 0) begin : g_bad_params
    $error("spi_frame_master: illegal parameter value");
  end

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StLoad,
    StShift,
    StHold,
    StGap
  } state_e;

  state_e          state_q, state_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic [DivW-1:0] div_q, div_d;
  logic [2:0]      bit_q, bit_d;
  // Bits still to be sent after the one currently on MOSI.
  logic [6:0]      shreg_q, shreg_d;
  logic            sck_q, sck_d;
  logic            cs_q, cs_d;
  logic            mosi_q, mosi_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [14:0]     count_q, count_d;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    sck_d   = sck_q;
    cs_d    = cs_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    count_d = count_q;

    case (state_q)
      StIdle: begin
        // A start coincident with the frame_done pulse is not taken.
        if (start && !done_q) begin
          state_d = StSetup;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          count_d = '0;
          tmr_d   = '0;
        end
      end
      StSetup: begin
        if (tmr_q == TmrW'(CS_SETUP - 1)) begin
          state_d = StLoad;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
      end
      StLoad: begin
        if (tx_valid) begin
          shreg_d = tx_data[6:0];
          mosi_d  = tx_data[7];
          count_d = count_q + 15'd1;
          bit_d   = '0;
          div_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (div_q == DivW'(CLK_DIV - 1)) begin
          div_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            sck_d = 1'b0;
            if (bit_q == 3'd7) begin
              state_d = (count_q < 15'(FRAME_BYTES)) ? StLoad : StHold;
              tmr_d   = '0;
            end else begin
              bit_d   = bit_q + 3'd1;
              mosi_d  = shreg_q[6];
              shreg_d = {shreg_q[5:0], 1'b0};
            end
          end
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StHold: begin
        if (tmr_q == TmrW'(CS_HOLD - 1)) begin
          state_d = StGap;
          cs_d    = 1'b1;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
      end
      StGap: begin
        if (tmr_q == TmrW'(CS_GAP - 1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      tmr_q   <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      sck_q   <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      sck_q   <= sck_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  assign tx_ready   = (state_q == StLoad);
  assign spi_clk    = sck_q;
  assign spi_cs     = cs_q;
  assign spi_mosi   = mosi_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign byte_count = count_q;

endmodule

// File: doc/spi_frame_master.md
Name: spi_frame_master

Overview:
- SPI mode-0 transmitter that streams one frame of pixel bytes to the panel controller's `spi_slave` input: `pin_spi_clk`, `pin_spi_cs`, `pin_spi_mosi`.
- Sits in the host-side / test-harness FPGA build. Consumes a valid/ready byte stream from a frame source, such as a pattern generator or a pixram read port.
- Frames each burst of FRAME_BYTES bytes with one chip-select assertion, so the receiver's byte counter restarts at 0 on every frame.
- Also serves as the stimulus driver for receiver-side loopback benches.

Parameters:
- CLK_DIV, 2: system clocks per SCK half-period. Legal values are 2 or more, giving SCK at most clock/4, which keeps the receiver's oversampling margin.
- FRAME_BYTES, 16384: bytes per frame, 1..16384. Matches the receiver's 14-bit byte address space.
- CS_SETUP, 2: clocks from CS falling to the first SCK rising edge (minimum 1).
- CS_HOLD, 2: clocks from the last SCK falling edge to CS rising (minimum 1).
- CS_GAP, 4: minimum clocks CS stays high before the next frame may start (minimum 1).

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins a frame when idle.
- tx_data  in  8  byte to send, MSB first.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  block will accept tx_data this cycle.
- spi_clk  out  1  SCK; idles low.
- spi_cs  out  1  chip select, active-low.
- spi_mosi  out  1  serial data.
- busy  out  1  high from frame start until the CS gap ends.
- frame_done  out  1  one-cycle pulse when the gap ends.
- byte_count  out  15  bytes accepted in the current frame.

Behaviour:
- Reset values, applied on the cycle after reset is sampled high, whether idle or mid-frame:
  - spi_cs=1, spi_clk=0, spi_mosi=0, tx_ready=0, busy=0, frame_done=0, byte_count=0, state=IDLE.
  - A partial byte or frame is abandoned; the receiver sees CS rise.
- All outputs are registered except tx_ready, which is `state==LOAD`.
- States: IDLE -> SETUP -> LOAD <-> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE:
  - start=1 -> SETUP; spi_cs<=0, busy<=1, byte_count<=0.
  - start is ignored in every other state.
- SETUP: hold CS_SETUP clocks, then -> LOAD.
- LOAD:
  - tx_ready=1.
  - On tx_valid&tx_ready: latch tx_data into the shift register, spi_mosi<=tx_data[7], byte_count+=1, -> SHIFT.
  - If tx_valid=0: stay in LOAD indefinitely (underrun stall) with CS low, SCK low and MOSI holding its last value. No SCK edges are produced, so the receiver is unaffected.
- SHIFT, per bit:
  - SCK low for CLK_DIV clocks, then high for CLK_DIV clocks.
  - On each SCK falling edge, MOSI advances to the next bit; the receiver samples on the rising edge.
  - A byte takes exactly 16*CLK_DIV clocks and 8 rising edges.
  - After bit 0's high phase, SCK returns low, then:
    - byte_count<FRAME_BYTES -> LOAD.
    - otherwise -> HOLD.
  - Minimum SCK-low time between bytes is CLK_DIV+1 clocks, because LOAD lasts at least one cycle.
- HOLD: CS_HOLD clocks with SCK low, then spi_cs<=1 -> GAP.
- GAP:
  - CS_GAP clocks.
  - On the last GAP cycle, frame_done<=1 for one cycle.
  - busy<=0 and -> IDLE.
  - start asserted coincident with frame_done is ignored; start is accepted from the next cycle.
- Counter widths and legality:
  - byte_count is 15 bits so FRAME_BYTES=16384 is representable; no wrap within a frame.
  - The bit counter is 3 bits and the divider counter is ceil(log2(CLK_DIV)) bits.
  - Illegal parameters (CLK_DIV<2, FRAME_BYTES=0 or >16384, any CS_* of 0) are rejected at elaboration.

Test Plan:
- CLK_DIV=2, FRAME_BYTES=2, bytes 0xA5, 0x3C always valid, start pulse:
  - CS low for exactly 2+1+32+1+32+2 clocks.
  - 16 SCK rising edges.
  - MOSI at the rising edges reads 1010_0101 then 0011_1100.
  - frame_done pulses once, 4 clocks after CS rises; byte_count=2 at done.
- Underrun: FRAME_BYTES=3, tx_valid dropped for 50 clocks after byte 1:
  - SCK stays low and CS stays low throughout the stall.
  - No extra edges; the total rising-edge count is 24.
- Reset mid-byte (after 3 SCK rising edges of byte 0):
  - Next cycle: spi_cs=1, spi_clk=0, busy=0, byte_count=0.
  - A following start sends a clean full frame.
- start pulses during SETUP, SHIFT, GAP, and on the frame_done cycle:
  - All are ignored; exactly one frame is sent.
- Loopback into the receiver, CLK_DIV=2, FRAME_BYTES=4, bytes 0x01, 0x80, 0xFF, 0x00, two back-to-back frames:
  - The receiver reports 4 done pulses per frame with matching data.
  - Its byte counter restarts at 0 on the second frame.
- FRAME_BYTES=16384 with an incrementing-byte source:
  - byte_count reaches 16384.
  - 131072 rising edges.
  - frame_done pulses once; no wrap.
